lmi_halt_ctl: RTL and testbench

Generates the pipeline halt vector `X_HALT_R` and the matching `IX_VAL`/`DC_VAL` fill-complete strobes that `lmi_watchd` monitors. It is the producer side of that miss/halt interface. It captures instruction-side misses (S stage) and data-side misses (W stage), then serialises them into single-outstanding memory fill requests over a req/ack handshake. It holds the corresponding halt bit until the fill returns, and flags a stuck fill with a sticky timeout.

---
 rtl/lmi_halt_pkg.sv | 24 ++
 rtl/lmi_halt_tmo.sv | 41 ++++
 rtl/lmi_halt_ctl.sv | 175 +++++++++++++++++
 tb/tb_lmi_halt_ctl.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmi_halt_pkg.sv
// Shared constants for the miss/halt producer: halt bit map, FSM encoding, request classes.
// No logic; purely declarative.
// No flow control.
package lmi_halt_pkg;

    localparam int IHALT       = 0;
    localparam int DHALT       = 1;
    localparam int RALU_HALT_E = 2;
    localparam int EXT         = 3;

    localparam logic [3:0] RALU_HALT_E_MASK = 4'b0100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IREQ  = 3'd1,
        IWAIT = 3'd2,
        DREQ  = 3'd3,
        DWAIT = 3'd4
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/lmi_halt_tmo.sv
// Saturating fill-wait counter with a sticky expiry flag.
// Expiry flag rises one cycle after the count reaches all-ones-minus-one.
// No backpressure; clear has priority over enable.
module lmi_halt_tmo #(
    parameter int TO_W = 10
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] CNT_MAX = '1;

    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + TO_W'(1);
        end
    end

    // Flag stays set until reset, even once the FSM leaves the wait state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (en && !clr && (cnt_nxt == CNT_MAX)) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmi_halt_ctl.sv
// Captures I/D misses, serialises them into single-outstanding fill requests, drives halt vector.
// Miss -> halt and MEM_REQ one cycle later; fill done -> halt clear and VAL strobe one cycle later.
// MEM_REQ/MEM_REQ_D/MEM_REQ_ADDR held stable until MEM_ACK; no overlap of fills.
module lmi_halt_ctl
    import lmi_halt_pkg::*;
#(
    parameter int HALT_W = 4,
    parameter int TO_W   = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        IX_MISS_S_R,
    input  logic [31:0]       LW_IADDR_S_R,
    input  logic              DC_MISS_W_R,
    input  logic [31:0]       DC_ADDR_W_R,
    input  logic              RALU_BUSY_E,
    input  logic              EXT_HALT,
    output logic              MEM_REQ,
    output logic              MEM_REQ_D,
    output logic [31:0]       MEM_REQ_ADDR,
    input  logic              MEM_ACK,
    input  logic              MEM_FILL_DONE,
    input  logic              MEM_FILL_D,
    output logic [HALT_W-1:0] X_HALT_R,
    output logic [1:0]        IX_VAL,
    output logic              DC_VAL,
    output logic              TIMEOUT
);

    state_t      state;
    logic        i_pend;
    logic        d_pend;
    logic [1:0]  i_mask;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic        ihalt_q;
    logic        dhalt_q;
    logic        ralu_q;
    logic        ext_q;

    logic        cap_i;
    logic        cap_d;
    logic        i_avail;
    logic        d_avail;
    logic [31:0] i_req_addr;
    logic [31:0] d_req_addr;
    logic        req_ack;
    logic        fill_i;
    logic        fill_d;
    logic        tmo_clr;
    logic        tmo_en;
    logic [HALT_W-1:0] halt_vec;

    // A class's halt bit covers both pending and in-flight, so held levels never recapture.
    assign cap_i      = (|IX_MISS_S_R) && !ihalt_q;
    assign cap_d      = DC_MISS_W_R && !dhalt_q;
    assign i_avail    = cap_i || i_pend;
    assign d_avail    = cap_d || d_pend;
    assign i_req_addr = cap_i ? LW_IADDR_S_R : i_addr;
    assign d_req_addr = cap_d ? DC_ADDR_W_R  : d_addr;

    assign req_ack = MEM_REQ && MEM_ACK;
    assign fill_i  = MEM_FILL_DONE && (MEM_FILL_D == REQ_I);
    assign fill_d  = MEM_FILL_DONE && (MEM_FILL_D == REQ_D);
    assign tmo_clr = ((state == IREQ) || (state == DREQ)) && req_ack;
    assign tmo_en  = (state == IWAIT) || (state == DWAIT);

    lmi_halt_tmo #(
        .TO_W (TO_W)
    ) u_tmo (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (TIMEOUT)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            i_pend       <= 1'b0;
            d_pend       <= 1'b0;
            i_mask       <= '0;
            i_addr       <= '0;
            d_addr       <= '0;
            ihalt_q      <= 1'b0;
            dhalt_q      <= 1'b0;
            ralu_q       <= 1'b0;
            ext_q        <= 1'b0;
            MEM_REQ      <= 1'b0;
            MEM_REQ_D    <= 1'b0;
            MEM_REQ_ADDR <= '0;
            IX_VAL       <= '0;
            DC_VAL       <= 1'b0;
        end else begin
            IX_VAL <= '0;
            DC_VAL <= 1'b0;
            ralu_q <= RALU_BUSY_E;
            ext_q  <= EXT_HALT;

            if (cap_i) begin
                i_pend  <= 1'b1;
                i_addr  <= LW_IADDR_S_R;
                i_mask  <= IX_MISS_S_R;
                ihalt_q <= 1'b1;
            end
            if (cap_d) begin
                d_pend  <= 1'b1;
                d_addr  <= DC_ADDR_W_R;
                dhalt_q <= 1'b1;
            end

            // Launches below override the pending set above when issued in the capture cycle.
            case (state)
                IDLE: begin
                    if (d_avail) begin
                        state        <= DREQ;
                        MEM_REQ      <= 1'b1;
                        MEM_REQ_D    <= REQ_D;
                        MEM_REQ_ADDR <= d_req_addr;
                        d_pend       <= 1'b0;
                    end else if (i_avail) begin
                        state        <= IREQ;
                        MEM_REQ      <= 1'b1;
                        MEM_REQ_D    <= REQ_I;
                        MEM_REQ_ADDR <= i_req_addr;
                        i_pend       <= 1'b0;
                    end
                end
                IREQ, DREQ: begin
                    if (req_ack) begin
                        MEM_REQ <= 1'b0;
                        state   <= (state == IREQ) ? IWAIT : DWAIT;
                    end
                end
                IWAIT: begin
                    if (fill_i) begin
                        ihalt_q <= 1'b0;
                        IX_VAL  <= i_mask;
                        state   <= IDLE;
                    end
                end
                DWAIT: begin
                    if (fill_d) begin
                        dhalt_q <= 1'b0;
                        DC_VAL  <= 1'b1;
                        if (i_avail) begin
                            state        <= IREQ;
                            MEM_REQ      <= 1'b1;
                            MEM_REQ_D    <= REQ_I;
                            MEM_REQ_ADDR <= i_req_addr;
                            i_pend       <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        halt_vec          = '0;
        halt_vec[IHALT]   = ihalt_q;
        halt_vec[DHALT]   = dhalt_q;
        halt_vec[EXT]     = ext_q;
        if (ralu_q) begin
            halt_vec = halt_vec | HALT_W'(RALU_HALT_E_MASK);
        end
    end

    assign X_HALT_R = halt_vec;

endmodule

// File: tb/tb_lmi_halt_ctl.sv
// Directed bench for lmi_halt_ctl: request serialisation, halt timing, timeout, reset recovery.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Bench always acks or resets the DUT itself; no open-ended waits.
module tb_lmi_halt_ctl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  IX_MISS_S_R;
    logic [31:0] LW_IADDR_S_R;
    logic        DC_MISS_W_R;
    logic [31:0] DC_ADDR_W_R;
    logic        RALU_BUSY_E;
    logic        EXT_HALT;
    logic        MEM_REQ;
    logic        MEM_REQ_D;
    logic [31:0] MEM_REQ_ADDR;
    logic        MEM_ACK;
    logic        MEM_FILL_DONE;
    logic        MEM_FILL_D;
    logic [3:0]  X_HALT_R;
    logic [1:0]  IX_VAL;
    logic        DC_VAL;
    logic        TIMEOUT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    lmi_halt_ctl #(
        .HALT_W (4),
        .TO_W   (4)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IX_MISS_S_R   (IX_MISS_S_R),
        .LW_IADDR_S_R  (LW_IADDR_S_R),
        .DC_MISS_W_R   (DC_MISS_W_R),
        .DC_ADDR_W_R   (DC_ADDR_W_R),
        .RALU_BUSY_E   (RALU_BUSY_E),
        .EXT_HALT      (EXT_HALT),
        .MEM_REQ       (MEM_REQ),
        .MEM_REQ_D     (MEM_REQ_D),
        .MEM_REQ_ADDR  (MEM_REQ_ADDR),
        .MEM_ACK       (MEM_ACK),
        .MEM_FILL_DONE (MEM_FILL_DONE),
        .MEM_FILL_D    (MEM_FILL_D),
        .X_HALT_R      (X_HALT_R),
        .IX_VAL        (IX_VAL),
        .DC_VAL        (DC_VAL),
        .TIMEOUT       (TIMEOUT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        IX_MISS_S_R   = 2'b00;
        LW_IADDR_S_R  = 32'h0;
        DC_MISS_W_R   = 1'b0;
        DC_ADDR_W_R   = 32'h0;
        RALU_BUSY_E   = 1'b0;
        EXT_HALT      = 1'b0;
        MEM_ACK       = 1'b0;
        MEM_FILL_DONE = 1'b0;
        MEM_FILL_D    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET       = 1'b1;
        DC_MISS_W_R = 1'b1;
        IX_MISS_S_R = 2'b11;
        tick();
        tick();
        checks++;
        if ({X_HALT_R, MEM_REQ, MEM_REQ_D, IX_VAL, DC_VAL, TIMEOUT} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outs: got halt=%b req=%b d=%b ixv=%b dcv=%b to=%b expected all 0",
                     X_HALT_R, MEM_REQ, MEM_REQ_D, IX_VAL, DC_VAL, TIMEOUT);
        end
        checks++;
        if (MEM_REQ_ADDR !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", MEM_REQ_ADDR);
        end
        idle_inputs();
        RESET = 1'b0;
        tick();
        checks++;
        if (MEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_req: got %b expected 0", MEM_REQ);
        end
    endtask

    task automatic test_data_miss();
        int halt_cnt = 0;
        int dcv_cnt  = 0;
        DC_MISS_W_R = 1'b1;
        DC_ADDR_W_R = 32'hDEAD_BEE0;
        MEM_FILL_D  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (X_HALT_R[1]) halt_cnt++;
            if (DC_VAL) dcv_cnt++;
            if (k == 1) begin
                checks++;
                if ({MEM_REQ, MEM_REQ_D} !== 2'b11) begin
                    errors++;
                    $display("FAIL dm_req: got req=%b d=%b expected 1 1", MEM_REQ, MEM_REQ_D);
                end
                checks++;
                if (MEM_REQ_ADDR !== 32'hDEAD_BEE0) begin
                    errors++;
                    $display("FAIL dm_addr: got %h expected deadbee0", MEM_REQ_ADDR);
                end
                DC_MISS_W_R = 1'b0;
                MEM_ACK     = 1'b1;
            end
            if (k == 2) begin
                checks++;
                if (MEM_REQ !== 1'b0) begin
                    errors++;
                    $display("FAIL dm_req_drop: got %b expected 0", MEM_REQ);
                end
                MEM_ACK = 1'b0;
            end
            if (k == 7) MEM_FILL_DONE = 1'b1;
            if (k == 8) begin
                checks++;
                if ({DC_VAL, X_HALT_R[1]} !== 2'b10) begin
                    errors++;
                    $display("FAIL dm_done: got dcv=%b dhalt=%b expected 1 0", DC_VAL, X_HALT_R[1]);
                end
                MEM_FILL_DONE = 1'b0;
            end
        end
        checks++;
        if (halt_cnt != 7) begin
            errors++;
            $display("FAIL dm_halt_len: got %0d cycles expected 7", halt_cnt);
        end
        checks++;
        if (dcv_cnt != 1) begin
            errors++;
            $display("FAIL dm_dcval_cnt: got %0d pulses expected 1", dcv_cnt);
        end
    endtask

    task automatic test_priority();
        int ixv_cnt = 0;
        IX_MISS_S_R  = 2'b10;
        LW_IADDR_S_R = 32'h0000_1000;
        DC_MISS_W_R  = 1'b1;
        DC_ADDR_W_R  = 32'h0000_2000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (IX_VAL != 2'b00) ixv_cnt++;
            case (k)
                1: begin
                    checks++;
                    if ({MEM_REQ, MEM_REQ_D, MEM_REQ_ADDR, X_HALT_R} !== {2'b11, 32'h0000_2000, 4'b0011}) begin
                        errors++;
                        $display("FAIL pri_first: got req=%b d=%b addr=%h halt=%b expected 1 1 00002000 0011",
                                 MEM_REQ, MEM_REQ_D, MEM_REQ_ADDR, X_HALT_R);
                    end
                    DC_MISS_W_R = 1'b0;
                    MEM_ACK     = 1'b1;
                end
                2: MEM_ACK = 1'b0;
                4: begin
                    MEM_FILL_DONE = 1'b1;
                    MEM_FILL_D    = 1'b1;
                end
                5: begin
                    MEM_FILL_DONE = 1'b0;
                    checks++;
                    if ({DC_VAL, MEM_REQ, MEM_REQ_D, MEM_REQ_ADDR, X_HALT_R} !== {3'b110, 32'h0000_1000, 4'b0001}) begin
                        errors++;
                        $display("FAIL pri_second: got dcv=%b req=%b d=%b addr=%h halt=%b expected 1 1 0 00001000 0001",
                                 DC_VAL, MEM_REQ, MEM_REQ_D, MEM_REQ_ADDR, X_HALT_R);
                    end
                    MEM_ACK = 1'b1;
                end
                6: begin
                    MEM_ACK = 1'b0;
                    checks++;
                    if (MEM_REQ !== 1'b0) begin
                        errors++;
                        $display("FAIL pri_req_drop: got %b expected 0", MEM_REQ);
                    end
                end
                7: begin
                    MEM_FILL_DONE = 1'b1;
                    MEM_FILL_D    = 1'b1;
                end
                8: begin
                    MEM_FILL_D = 1'b0;
                    checks++;
                    if ({X_HALT_R[0], IX_VAL} !== 3'b100) begin
                        errors++;
                        $display("FAIL pri_wrong_class: got ihalt=%b ixv=%b expected 1 00", X_HALT_R[0], IX_VAL);
                    end
                end
                9: begin
                    MEM_FILL_DONE = 1'b0;
                    checks++;
                    if ({IX_VAL, X_HALT_R} !== 6'b10_0000) begin
                        errors++;
                        $display("FAIL pri_ixval: got ixv=%b halt=%b expected 10 0000", IX_VAL, X_HALT_R);
                    end
                    IX_MISS_S_R = 2'b00;
                end
                10: begin
                    checks++;
                    if ({IX_VAL, MEM_REQ} !== 3'b000) begin
                        errors++;
                        $display("FAIL pri_after: got ixv=%b req=%b expected 00 0", IX_VAL, MEM_REQ);
                    end
                end
                default: ;
            endcase
        end
        checks++;
        if (ixv_cnt != 1) begin
            errors++;
            $display("FAIL pri_ixval_cnt: got %0d pulses expected 1", ixv_cnt);
        end
    endtask

    task automatic test_ack_stall();
        int bad = 0;
        IX_MISS_S_R  = 2'b11;
        LW_IADDR_S_R = 32'hCAFE_0040;
        MEM_FILL_D   = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k <= 20) begin
                if ({MEM_REQ, MEM_REQ_D, MEM_REQ_ADDR} !== {2'b10, 32'hCAFE_0040}) bad++;
            end
            if (k == 20) begin
                checks++;
                if (TIMEOUT !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_timeout: got %b expected 0", TIMEOUT);
                end
                MEM_ACK = 1'b1;
            end
            if (k == 21) begin
                MEM_ACK = 1'b0;
                checks++;
                if (MEM_REQ !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_req_drop: got %b expected 0", MEM_REQ);
                end
            end
            if (k == 22) MEM_FILL_DONE = 1'b1;
            if (k == 23) begin
                MEM_FILL_DONE = 1'b0;
                checks++;
                if ({IX_VAL, X_HALT_R[0]} !== 3'b110) begin
                    errors++;
                    $display("FAIL stall_ixval: got ixv=%b ihalt=%b expected 11 0", IX_VAL, X_HALT_R[0]);
                end
                IX_MISS_S_R = 2'b00;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad);
        end
    endtask

    task automatic test_i_then_d();
        IX_MISS_S_R  = 2'b01;
        LW_IADDR_S_R = 32'h0000_3000;
        MEM_FILL_D   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            case (k)
                1: begin
                    checks++;
                    if ({MEM_REQ, MEM_REQ_D, MEM_REQ_ADDR} !== {2'b10, 32'h0000_3000}) begin
                        errors++;
                        $display("FAIL itd_ireq: got req=%b d=%b addr=%h expected 1 0 00003000",
                                 MEM_REQ, MEM_REQ_D, MEM_REQ_ADDR);
                    end
                    MEM_ACK = 1'b1;
                end
                2: begin
                    MEM_ACK     = 1'b0;
                    DC_MISS_W_R = 1'b1;
                    DC_ADDR_W_R = 32'h0000_4000;
                end
                3: begin
                    checks++;
                    if ({MEM_REQ, X_HALT_R} !== 5'b0_0011) begin
                        errors++;
                        $display("FAIL itd_dpend: got req=%b halt=%b expected 0 0011", MEM_REQ, X_HALT_R);
                    end
                end
                4: MEM_FILL_DONE = 1'b1;
                5: begin
                    MEM_FILL_DONE = 1'b0;
                    checks++;
                    if ({IX_VAL, MEM_REQ, X_HALT_R} !== 7'b01_0_0010) begin
                        errors++;
                        $display("FAIL itd_idone: got ixv=%b req=%b halt=%b expected 01 0 0010",
                                 IX_VAL, MEM_REQ, X_HALT_R);
                    end
                    IX_MISS_S_R = 2'b00;
                end
                6: begin
                    checks++;
                    if ({MEM_REQ, MEM_REQ_D, MEM_REQ_ADDR} !== {2'b11, 32'h0000_4000}) begin
                        errors++;
                        $display("FAIL itd_dreq: got req=%b d=%b addr=%h expected 1 1 00004000",
                                 MEM_REQ, MEM_REQ_D, MEM_REQ_ADDR);
                    end
                    MEM_ACK = 1'b1;
                end
                7: begin
                    MEM_ACK       = 1'b0;
                    MEM_FILL_DONE = 1'b1;
                    MEM_FILL_D    = 1'b1;
                end
                8: begin
                    MEM_FILL_DONE = 1'b0;
                    checks++;
                    if ({DC_VAL, X_HALT_R} !== 5'b1_0000) begin
                        errors++;
                        $display("FAIL itd_ddone: got dcv=%b halt=%b expected 1 0000", DC_VAL, X_HALT_R);
                    end
                    DC_MISS_W_R = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_ralu();
        logic [7:0] rp = 8'b1011_0010;
        logic [7:0] ep = 8'b0110_1100;
        int bad = 0;
        // Leave a data request un-acked so the FSM is mid-transfer while the copies toggle.
        DC_MISS_W_R = 1'b1;
        DC_ADDR_W_R = 32'h0000_5000;
        tick();
        DC_MISS_W_R = 1'b0;
        for (int i = 0; i < 8; i++) begin
            RALU_BUSY_E = rp[i];
            EXT_HALT    = ep[i];
            tick();
            if (X_HALT_R !== {ep[i], rp[i], 2'b10}) begin
                bad++;
                $display("FAIL ralu_follow[%0d]: got %b expected %b", i, X_HALT_R, {ep[i], rp[i], 2'b10});
            end
        end
        checks++;
        if (bad != 0) errors++;
        RALU_BUSY_E = 1'b0;
        EXT_HALT    = 1'b0;
        MEM_ACK     = 1'b1;
        tick();
        MEM_ACK       = 1'b0;
        MEM_FILL_DONE = 1'b1;
        MEM_FILL_D    = 1'b1;
        tick();
        MEM_FILL_DONE = 1'b0;
        checks++;
        if ({DC_VAL, X_HALT_R} !== 5'b1_0000) begin
            errors++;
            $display("FAIL ralu_cleanup: got dcv=%b halt=%b expected 1 0000", DC_VAL, X_HALT_R);
        end
    endtask

    task automatic test_timeout();
        DC_MISS_W_R = 1'b1;
        DC_ADDR_W_R = 32'h0000_6000;
        MEM_FILL_D  = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) begin
                DC_MISS_W_R = 1'b0;
                MEM_ACK     = 1'b1;
            end
            if (k == 2) MEM_ACK = 1'b0;
            if (k == 16) begin
                checks++;
                if (TIMEOUT !== 1'b0) begin
                    errors++;
                    $display("FAIL to_early: got %b expected 0", TIMEOUT);
                end
            end
            if (k == 17) begin
                checks++;
                if (TIMEOUT !== 1'b1) begin
                    errors++;
                    $display("FAIL to_rise: got %b expected 1", TIMEOUT);
                end
            end
            if (k == 30) begin
                checks++;
                if ({TIMEOUT, X_HALT_R[1]} !== 2'b11) begin
                    errors++;
                    $display("FAIL to_sticky: got to=%b dhalt=%b expected 1 1", TIMEOUT, X_HALT_R[1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        RESET       = 1'b1;
        RALU_BUSY_E = 1'b1;
        tick();
        RESET       = 1'b0;
        RALU_BUSY_E = 1'b0;
        checks++;
        if ({X_HALT_R, MEM_REQ, MEM_REQ_D, IX_VAL, DC_VAL, TIMEOUT} !== 10'b0) begin
            errors++;
            $display("FAIL rst_mid_outs: got halt=%b req=%b d=%b ixv=%b dcv=%b to=%b expected all 0",
                     X_HALT_R, MEM_REQ, MEM_REQ_D, IX_VAL, DC_VAL, TIMEOUT);
        end
        checks++;
        if (MEM_REQ_ADDR !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_addr: got %h expected 0", MEM_REQ_ADDR);
        end
        MEM_FILL_DONE = 1'b1;
        MEM_FILL_D    = 1'b1;
        tick();
        MEM_FILL_DONE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if ({DC_VAL, MEM_REQ, X_HALT_R} !== 6'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_stray_fill: got %0d bad cycles expected 0", bad);
        end
        DC_MISS_W_R = 1'b1;
        DC_ADDR_W_R = 32'h0000_7000;
        tick();
        DC_MISS_W_R = 1'b0;
        checks++;
        if ({MEM_REQ, MEM_REQ_ADDR} !== {1'b1, 32'h0000_7000}) begin
            errors++;
            $display("FAIL rst_recover_req: got req=%b addr=%h expected 1 00007000", MEM_REQ, MEM_REQ_ADDR);
        end
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK       = 1'b0;
        MEM_FILL_DONE = 1'b1;
        tick();
        MEM_FILL_DONE = 1'b0;
        checks++;
        if ({DC_VAL, TIMEOUT} !== 2'b10) begin
            errors++;
            $display("FAIL rst_recover_done: got dcv=%b to=%b expected 1 0", DC_VAL, TIMEOUT);
        end
    endtask

    initial begin
        test_reset();
        test_data_miss();
        test_priority();
        test_ack_stall();
        test_i_then_d();
        test_ralu();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
